// File: rtl/rc_capture_pkg.sv
// rc_capture_pkg: register map, channel FSM states and width field size
// shared by the RC pulse capture block.
package rc_capture_pkg;
    localparam int WIDTH_BITS   = 12;
    localparam int ADDR_WIDTH0  = 0;
    localparam int ADDR_NEW     = 12;
    localparam int ADDR_LOST    = 13;
    localparam int ADDR_INTMASK = 14;
    localparam int ADDR_CTRL    = 15;

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_OVER} chan_state_e;

    function automatic logic [15:0] width_word(input logic lost, input logic [WIDTH_BITS-1:0] width);
        return {~lost, {(15-WIDTH_BITS){1'b0}}, width};
    endfunction
endpackage

// File: rtl/rc_capture_chan.sv
// rc_capture_chan: one RC pulse measurement channel (sync, edge detect, FSM, timeout).
// Define RC_CAPTURE_FILTER_EN to add a 3-sample stability filter after the synchronizer.
module rc_capture_chan
    import rc_capture_pkg::*;
#(
    parameter int MIN_US     = 500,
    parameter int MAX_US     = 3000,
    parameter int TIMEOUT_US = 25000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_pin,
    input  logic                  i_tick,
    input  logic                  i_enable,
    input  logic                  i_clr,
    output logic [WIDTH_BITS-1:0] o_width,
    output logic                  o_new,
    output logic                  o_lost
);
    localparam int TW = $clog2(TIMEOUT_US + 1);
    localparam logic [WIDTH_BITS:0] MIN_C = (WIDTH_BITS+1)'(MIN_US);
    localparam logic [WIDTH_BITS:0] MAX_C = (WIDTH_BITS+1)'(MAX_US);
    localparam logic [TW-1:0]       TO_MAX = TW'(TIMEOUT_US);

    logic [1:0]            r_sync;
    logic                  r_s_prev;
    logic                  w_s;
    logic                  w_rise;
    logic                  w_fall;
    chan_state_e           r_state;
    chan_state_e           w_state_nx;
    logic [WIDTH_BITS-1:0] r_cnt;
    logic [WIDTH_BITS-1:0] w_cnt_nx;
    logic [WIDTH_BITS:0]   w_cnt_inc;
    logic                  w_accept;
    logic [WIDTH_BITS-1:0] r_width;
    logic                  r_new;
    logic                  r_lost;
    logic [TW-1:0]         r_to;

    // Sync and edge flops reset high so a pin already high at release needs a fresh rise.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], i_pin};

`ifdef RC_CAPTURE_FILTER_EN
    logic [1:0] r_hist;
    logic       r_filt;
    assign w_s = (r_hist == {2{r_sync[1]}}) ? r_sync[1] : r_filt;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_hist <= 2'b11;
            r_filt <= 1'b1;
        end else begin
            r_hist <= {r_hist[0], r_sync[1]};
            r_filt <= w_s;
        end
`else
    assign w_s = r_sync[1];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_s_prev <= 1'b1;
        else          r_s_prev <= w_s;

    assign w_rise    = w_s & ~r_s_prev;
    assign w_fall    = ~w_s & r_s_prev;
    assign w_cnt_inc = {1'b0, r_cnt} + (WIDTH_BITS+1)'(i_tick);

    // The tick coinciding with the fall strobe is counted, so width is never short.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_accept   = 1'b0;
        if (!i_enable) w_state_nx = ST_IDLE;
        else case (r_state)
            ST_IDLE: if (w_rise) begin
                w_state_nx = ST_HIGH;
                w_cnt_nx   = '0;
            end
            ST_HIGH: if (w_fall) begin
                w_state_nx = ST_IDLE;
                w_accept   = w_cnt_inc >= MIN_C && w_cnt_inc <= MAX_C;
            end else if (w_cnt_inc > MAX_C) w_state_nx = ST_OVER;
            else w_cnt_nx = w_cnt_inc[WIDTH_BITS-1:0];
            ST_OVER: if (w_fall) w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_width <= '0;
            r_new   <= 1'b0;
            r_lost  <= 1'b1;
            r_to    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_new   <= w_accept | (r_new & ~i_clr);
            if (w_accept) begin
                r_width <= w_cnt_inc[WIDTH_BITS-1:0];
                r_to    <= '0;
                r_lost  <= 1'b0;
            end else begin
                if (i_enable && i_tick && r_to != TO_MAX) r_to <= r_to + 1'b1;
                if (r_to == TO_MAX) r_lost <= 1'b1;
            end
        end

    assign o_width = r_width;
    assign o_new   = r_new;
    assign o_lost  = r_lost;
endmodule

// File: rtl/rc_pulse_capture.sv
// rc_pulse_capture: multi-channel RC receiver pulse decoder with bus registers and interrupt.
// Optional glitch filter in each channel is enabled by defining RC_CAPTURE_FILTER_EN.
module rc_pulse_capture
    import rc_capture_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int PRESCALE   = 50,
    parameter int MIN_US     = 500,
    parameter int MAX_US     = 3000,
    parameter int TIMEOUT_US = 25000
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic [3:0]        Addr,
    output logic [15:0]       DataRd,
    input  logic [15:0]       DataWr,
    input  logic              En,
    input  logic              Rd,
    input  logic              Wr,
    input  logic [NUM_CH-1:0] PulseIn,
    output logic              IntStatus,
    input  logic              IntReset
);
    localparam int PW = $clog2(PRESCALE + 1);

    logic [PW-1:0]                       r_pre;
    logic                                r_enable;
    logic [NUM_CH-1:0]                   r_intmask;
    logic                                w_tick;
    logic                                w_wr;
    logic [NUM_CH-1:0]                   w_new;
    logic [NUM_CH-1:0]                   w_lost;
    logic [NUM_CH-1:0]                   w_clr;
    logic [NUM_CH-1:0][WIDTH_BITS-1:0]   w_width;
    logic [15:0]                         w_word [16];
    logic                                w_unused;

    assign w_wr   = En & Wr;
    assign w_tick = r_enable && r_pre == PW'(PRESCALE - 1);

    always_ff @(posedge Clk or negedge ResetN)
        if (!ResetN)                  r_pre <= '0;
        else if (!r_enable || w_tick) r_pre <= '0;
        else                          r_pre <= r_pre + 1'b1;

    always_ff @(posedge Clk or negedge ResetN)
        if (!ResetN) begin
            r_enable  <= 1'b0;
            r_intmask <= '0;
        end else if (w_wr) begin
            if (Addr == 4'(ADDR_INTMASK)) r_intmask <= DataWr[NUM_CH-1:0];
            if (Addr == 4'(ADDR_CTRL))    r_enable  <= DataWr[0];
        end

    assign w_clr = ((w_wr && Addr == 4'(ADDR_NEW)) ? DataWr[NUM_CH-1:0] : '0) | (IntReset ? r_intmask : '0);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        rc_capture_chan #(
            .MIN_US     (MIN_US),
            .MAX_US     (MAX_US),
            .TIMEOUT_US (TIMEOUT_US)
        ) u_chan (
            .i_clk    (Clk),
            .i_rst_n  (ResetN),
            .i_pin    (PulseIn[g]),
            .i_tick   (w_tick),
            .i_enable (r_enable),
            .i_clr    (w_clr[g]),
            .o_width  (w_width[g]),
            .o_new    (w_new[g]),
            .o_lost   (w_lost[g])
        );
    end

    always_comb begin
        for (int k = 0; k < 16; k++) w_word[k] = '0;
        for (int k = 0; k < NUM_CH; k++) w_word[ADDR_WIDTH0 + k] = width_word(w_lost[k], w_width[k]);
        w_word[ADDR_NEW]     = 16'(w_new);
        w_word[ADDR_LOST]    = 16'(w_lost);
        w_word[ADDR_INTMASK] = 16'(r_intmask);
        w_word[ADDR_CTRL]    = {15'b0, r_enable};
    end

    assign DataRd    = (En & Rd) ? w_word[Addr] : '0;
    assign IntStatus = |(w_new & r_intmask);
    assign w_unused  = ^DataWr;
endmodule

// File: tb/tb_rc_pulse_capture.sv
// tb_rc_pulse_capture: directed self-checking bench for rc_pulse_capture
// (4 channels, 2 Clk per tick, accepted range 50..300 ticks, timeout 1000 ticks).
module tb_rc_pulse_capture;
    localparam int P = 2;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic [3:0]  Addr = '0;
    logic [15:0] DataRd;
    logic [15:0] DataWr = '0;
    logic        En = 1'b0;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic [3:0]  PulseIn = '0;
    logic        IntStatus;
    logic        IntReset = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] d;

    rc_pulse_capture #(
        .NUM_CH     (4),
        .PRESCALE   (P),
        .MIN_US     (50),
        .MAX_US     (300),
        .TIMEOUT_US (1000)
    ) dut (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .Addr      (Addr),
        .DataRd    (DataRd),
        .DataWr    (DataWr),
        .En        (En),
        .Rd        (Rd),
        .Wr        (Wr),
        .PulseIn   (PulseIn),
        .IntStatus (IntStatus),
        .IntReset  (IntReset)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [15:0] obs, input logic [15:0] exp_a, input logic [15:0] exp_b);
        n_checks++;
        assert (obs === exp_a || obs === exp_b) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h or 0x%h", tag, obs, exp_a, exp_b);
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] v);
        @(negedge Clk);
        En = 1'b1; Rd = 1'b1; Addr = a;
        #1 v = DataRd;
        En = 1'b0; Rd = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
        logic [15:0] v;
        rd(a, v);
        check(tag, v, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] v);
        @(negedge Clk);
        En = 1'b1; Wr = 1'b1; Addr = a; DataWr = v;
        @(negedge Clk);
        En = 1'b0; Wr = 1'b0;
    endtask

    // Pin is high for exactly ticks*P rising edges.
    task automatic pulse(input int ch, input int ticks);
        @(negedge Clk);
        PulseIn[ch] = 1'b1;
        repeat (ticks * P) @(negedge Clk);
        PulseIn[ch] = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    // Fires a clear (write-1-clear or IntReset) on the edge where the width latches:
    // the third rising edge after the pin falls.
    task automatic pulse_collide(input int ch, input int ticks, input bit use_int);
        @(negedge Clk);
        PulseIn[ch] = 1'b1;
        repeat (ticks * P) @(negedge Clk);
        PulseIn[ch] = 1'b0;
        repeat (2) @(negedge Clk);
        if (use_int) IntReset = 1'b1;
        else begin
            En = 1'b1; Wr = 1'b1; Addr = 4'd12; DataWr = 16'(1 << ch);
        end
        @(negedge Clk);
        IntReset = 1'b0; En = 1'b0; Wr = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        repeat (4) @(negedge Clk);
        ResetN = 1'b1;
        chk_reg("rst_width0", 4'd0, 16'h0000);
        chk_reg("rst_new", 4'd12, 16'h0000);
        chk_reg("rst_lost", 4'd13, 16'h000F);
        chk_reg("rst_intmask", 4'd14, 16'h0000);
        chk_reg("rst_ctrl", 4'd15, 16'h0000);
        chk_reg("rst_unused_addr", 4'd5, 16'h0000);
        check("rst_intstatus", 16'(IntStatus), 16'h0000);

        wr(4'd15, 16'h0001);
        wr(4'd14, 16'h0001);
        chk_reg("ctrl_rb", 4'd15, 16'h0001);
        chk_reg("intmask_rb", 4'd14, 16'h0001);

        pulse(0, 150);
        rd(4'd0, d);
        check2("accept_width0", d, 16'h8096, 16'h8097);
        chk_reg("accept_new", 4'd12, 16'h0001);
        chk_reg("accept_lost", 4'd13, 16'h000E);
        check("accept_int", 16'(IntStatus), 16'h0001);

        wr(4'd12, 16'h0001);
        chk_reg("w1c_new", 4'd12, 16'h0000);
        check("w1c_int", 16'(IntStatus), 16'h0000);

        pulse(1, 20);
        chk_reg("runt_width1", 4'd1, 16'h0000);
        chk_reg("runt_new", 4'd12, 16'h0000);
        pulse(1, 350);
        chk_reg("over_width1", 4'd1, 16'h0000);
        chk_reg("over_new", 4'd12, 16'h0000);
        pulse(1, 100);
        rd(4'd1, d);
        check2("recover_width1", d, 16'h8064, 16'h8065);
        chk_reg("recover_new", 4'd12, 16'h0002);
        check("masked_int", 16'(IntStatus), 16'h0000);
        wr(4'd12, 16'h000F);

        pulse(2, 100);
        rd(4'd2, d);
        check2("to_width2", d, 16'h8064, 16'h8065);
        rd(4'd13, d);
        check("to_not_lost", d & 16'h0004, 16'h0000);
        repeat (1900) @(negedge Clk);
        rd(4'd13, d);
        check("to_still_ok", d & 16'h0004, 16'h0000);
        repeat (150) @(negedge Clk);
        rd(4'd13, d);
        check("to_lost", d & 16'h0004, 16'h0004);
        rd(4'd2, d);
        check2("to_width2_invalid", d, 16'h0064, 16'h0065);
        pulse(2, 120);
        rd(4'd13, d);
        check("to_relock", d & 16'h0004, 16'h0000);
        rd(4'd2, d);
        check2("to_width2_new", d, 16'h8078, 16'h8079);
        wr(4'd12, 16'h000F);

        wr(4'd14, 16'h0009);
        pulse_collide(3, 100, 1'b0);
        rd(4'd12, d);
        check("coll_w1c", d & 16'h0008, 16'h0008);
        wr(4'd12, 16'h0008);
        rd(4'd12, d);
        check("w1c_ch3", d & 16'h0008, 16'h0000);
        pulse_collide(3, 100, 1'b1);
        rd(4'd12, d);
        check("coll_intreset", d & 16'h0008, 16'h0008);
        check("coll_int", 16'(IntStatus), 16'h0001);
        @(negedge Clk);
        IntReset = 1'b1;
        @(negedge Clk);
        IntReset = 1'b0;
        rd(4'd12, d);
        check("intreset_new", d & 16'h0008, 16'h0000);
        check("intreset_int", 16'(IntStatus), 16'h0000);

        @(negedge Clk);
        PulseIn[0] = 1'b1;
        repeat (100) @(negedge Clk);
        ResetN = 1'b0;
        repeat (3) @(negedge Clk);
        ResetN = 1'b1;
        chk_reg("mrst_width0", 4'd0, 16'h0000);
        chk_reg("mrst_width2", 4'd2, 16'h0000);
        chk_reg("mrst_new", 4'd12, 16'h0000);
        chk_reg("mrst_lost", 4'd13, 16'h000F);
        chk_reg("mrst_intmask", 4'd14, 16'h0000);
        chk_reg("mrst_ctrl", 4'd15, 16'h0000);
        wr(4'd15, 16'h0001);
        repeat (200) @(negedge Clk);
        PulseIn[0] = 1'b0;
        repeat (6) @(negedge Clk);
        chk_reg("mrst_nocap_width", 4'd0, 16'h0000);
        chk_reg("mrst_nocap_new", 4'd12, 16'h0000);
        pulse(0, 150);
        rd(4'd0, d);
        check2("mrst_cap_width", d, 16'h8096, 16'h8097);
        chk_reg("mrst_cap_new", 4'd12, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rc_pulse_capture.md
# rc_pulse_capture

Multi-channel RC receiver pulse decoder: the input-side counterpart of the RC servo pulse generator. Each channel measures the high time of a standard RC pulse (nominally 1000–2000 µs, 50 Hz frame) in microsecond ticks and flags new and lost signals. The block sits on the FPGA peripheral bus behind `Primary`, decoded by an `En` chip-select like the other peripherals, and reports through an `IntStatus`/`IntReset` pair.

## Interface
- `NUM_CH`, default 8: number of capture channels, 1..12.
- `PRESCALE`, default 50: Clk cycles per 1 µs tick.
- `MIN_US`, default 500: shortest accepted pulse in ticks.
- `MAX_US`, default 3000: longest accepted pulse in ticks.
- `TIMEOUT_US`, default 25000: ticks without a valid pulse before a channel is declared lost.

Ports:
- `Clk` in 1: single system clock. All logic is synchronous to its rising edge.
- `ResetN` in 1: asynchronous active-low reset.
- `Addr` in 4: word address (bus Addr[4:1]).
- `DataRd` out 16: combinational read data.
- `DataWr` in 16: write data.
- `En` in 1: block select.
- `Rd` in 1: read strobe.
- `Wr` in 1: single-cycle write strobe.
- `PulseIn` in NUM_CH: asynchronous pulse inputs from the pins.
- `IntStatus` out 1: level interrupt request.
- `IntReset` in 1: single-cycle interrupt acknowledge.

## Operation
- Register map (16-bit words):
  - Addr k < NUM_CH: WIDTH[k], read-only. Bits [11:0] hold the last accepted width in ticks; bit 15 is VALID, which equals ~LOST[k].
  - Addr 12: NEW[NUM_CH-1:0]. Reading returns the flags; writing 1 to a bit clears it.
  - Addr 13: LOST[NUM_CH-1:0], read-only.
  - Addr 14: INTMASK, read/write.
  - Addr 15: CTRL, read/write. Bit 0 is ENABLE.
  - Unused addresses and unused bits read 0.
- Prescaler: one free-running counter shared by all channels. It emits a one-Clk `tick` every PRESCALE cycles and runs only while ENABLE=1; when ENABLE=0 it is held at 0.
- Per-channel FSM, driven by the conditioned input level `s` with rise/fall edge strobes:
  - IDLE: a rising edge clears `cnt` and moves to HIGH.
  - HIGH: `cnt` increments on each tick.
    - `cnt` > MAX_US: discard the pulse, go to OVER.
    - Falling edge with MIN_US ≤ `cnt` ≤ MAX_US: latch WIDTH, set NEW, clear LOST, zero the timeout counter, go to IDLE.
    - Falling edge with `cnt` < MIN_US: runt pulse, discard, go to IDLE.
  - OVER: a falling edge returns to IDLE; no register update.
- Timeout counter per channel:
  - Increments on each tick and saturates at TIMEOUT_US.
  - Reaching TIMEOUT_US sets LOST.
  - It is zeroed only on an accepted pulse.
- ENABLE=0 forces every FSM to IDLE and freezes the timeout counters. WIDTH, NEW and LOST hold their values.
- `IntStatus` = |(NEW & INTMASK). `IntReset` clears the NEW bits whose INTMASK bit is set.
- Collisions: a hardware set of NEW in the same cycle as a write-1-clear or `IntReset` leaves NEW set (set wins).

## Timing
- Reset values:
  - WIDTH = 0, NEW = 0, LOST = all 1, INTMASK = 0, CTRL = 0.
  - FSMs in IDLE; prescaler and counters at 0.
  - `IntStatus` = 0; `DataRd` reflects these values.
- Input conditioning: a 2-flop synchronizer followed by an edge-detect flop. An input edge becomes a strobe 3 Clk cycles later.
- WIDTH and NEW update on the Clk edge after the fall strobe. `IntStatus` follows in the same cycle, since it is combinational from the registers.
- Resolution: measured width is within −0/+1 tick of the true pulse width.
- Writes take effect on the Clk edge where `En & Wr` is high. Reads are combinational with no side effects.
- Reset asserted mid-pulse aborts the measurement. The next capture needs a fresh rising edge after `ResetN` deasserts; a pin already high at release goes to OVER-equivalent behaviour by waiting for the next rise.

## Configuration
- `RC_CAPTURE_FILTER_EN` defined:
  - A 3-sample stability filter follows the synchronizer; the filtered level changes only after 3 identical consecutive samples.
  - Adds 2 Clk of latency and rejects glitches shorter than 3 Clk.
- Undefined: the synchronizer output drives `s` directly.

## Structure
- `rc_capture_pkg` holds:
  - register address constants (WIDTH base, NEW=12, LOST=13, INTMASK=14, CTRL=15);
  - the channel FSM state type (IDLE, HIGH, OVER);
  - the width field size of 12 bits.
- Sub-module `rc_capture_chan`, instantiated NUM_CH times. It contains the synchronizer, the optional filter, the FSM, the width and timeout counters and the WIDTH/NEW/LOST state.
- The top level holds the prescaler, the bus decode/read mux, INTMASK, CTRL and the interrupt logic.

## Test plan
- Accepted pulse: PRESCALE=50, ENABLE=1, INTMASK=0x01, 1500 µs pulse on ch0 → WIDTH[0] reads 1500 or 1501 with bit15=1, NEW=0x01, `IntStatus`=1.
- Interrupt clear: write 0x0001 to addr 12 → NEW=0, `IntStatus`=0.
- Runt, overlong and recovery:
  - 200 µs pulse on ch1 → no WIDTH/NEW change.
  - 3500 µs pulse → no change.
  - Following 1000 µs pulse → WIDTH[1]=1000.
- Timeout: ch2 receives a valid pulse, then stays low for 25 ms → LOST bit 2 set, WIDTH[2] bit15=0. The next valid pulse clears LOST.
- Set-wins collisions: write-1-clear to NEW bit 3 in the exact cycle ch3 latches a width → NEW bit 3 remains 1. Same result for `IntReset`.
- Reset mid-pulse: assert `ResetN` low mid-pulse → all registers return to reset values; with the pin high at release, no capture occurs until the next full pulse.
- Filter build (`RC_CAPTURE_FILTER_EN` defined): 2-Clk glitch on ch0 → ignored.
